// File: rtl/branch_target_buffer_pkg.sv
// Shared constants for the branch target buffer: PC width, tag slice and direction encoding.
package branch_target_buffer_pkg;

   localparam int PC_W   = 32;
   localparam int TAG_HI = 31;
   localparam int TAG_LO = 2;
   localparam int TAG_W  = TAG_HI - TAG_LO + 1;

   localparam logic DIR_NOT_TAKEN = 1'b1;
   localparam logic DIR_TAKEN     = 1'b0;

   typedef logic [PC_W-1:0]  pc_t;
   typedef logic [TAG_W-1:0] tag_t;

   function automatic logic dir_of(input logic taken);
      return taken ? DIR_TAKEN : DIR_NOT_TAKEN;
   endfunction

endpackage

// File: rtl/btb_victim_select.sv
// Allocation victim: lowest-index invalid line, or the round-robin pointer once every line is valid.
module btb_victim_select #(
   parameter int WIDTH    = 4,
   parameter int LINE_NUM = 16
) (
   input  logic [LINE_NUM-1:0] valid,
   input  logic [WIDTH-1:0]    rr_ptr,
   output logic [WIDTH-1:0]    victim,
   output logic                all_valid
);

   // NOTE: every output of an always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      victim    = rr_ptr;
      all_valid = &valid;
      // Walk downward so the lowest invalid index is the last one written.
      for (int i = LINE_NUM - 1; i >= 0; i--) begin
         if (!valid[i]) victim = WIDTH'(i);
      end
   end

endmodule

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer driving branch_state_machine allocate/train commands.
// Optional BTB_FLUSH_EN adds a flush port that invalidates every line.
module branch_target_buffer
   import branch_target_buffer_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int LINE_NUM = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PC_W-1:0]  request_pc,
   input  logic             request_state,
   output logic [WIDTH-1:0] request_line_index,
   output logic             request_miss,
   output logic [PC_W-1:0]  predict_pc,
   input  logic             update_en,
   input  logic [PC_W-1:0]  update_pc,
   input  logic [PC_W-1:0]  update_target,
   input  logic             update_taken,
   output logic             replace_en,
   output logic [WIDTH-1:0] replace_line_index,
   output logic             static_branch_predict,
   output logic             fresh_en,
   output logic [WIDTH-1:0] fresh_line_index,
   output logic             dynamic_branch_predict
`ifdef BTB_FLUSH_EN
   ,
   input  logic             flush
`endif
);

   logic [LINE_NUM-1:0] valid;
   tag_t                tag_mem    [LINE_NUM];
   pc_t                 target_mem [LINE_NUM];

   logic [LINE_NUM-1:0] req_match, upd_match;
   logic [WIDTH-1:0]    req_idx, upd_idx, victim, rr_ptr, wr_idx;
   pc_t                 req_target;
   logic                req_hit, upd_hit, all_valid, write_go;
   logic                unused_pc_bits;

   assign unused_pc_bits = ^update_pc[TAG_LO-1:0];

   // Tags are unique, so a one-hot OR recovers the matching index and target.
   always_comb begin
      req_match  = '0;
      upd_match  = '0;
      req_idx    = '0;
      upd_idx    = '0;
      req_target = '0;
      for (int i = 0; i < LINE_NUM; i++) begin
         req_match[i] = valid[i] && (tag_mem[i] == request_pc[TAG_HI:TAG_LO]);
         upd_match[i] = valid[i] && (tag_mem[i] == update_pc[TAG_HI:TAG_LO]);
         if (req_match[i]) begin
            req_idx    |= WIDTH'(i);
            req_target |= target_mem[i];
         end
         if (upd_match[i]) upd_idx |= WIDTH'(i);
      end
   end

   assign req_hit            = |req_match;
   assign upd_hit            = |upd_match;
   assign request_miss       = ~req_hit;
   assign request_line_index = req_idx;
   assign predict_pc         = (req_hit && request_state) ? req_target : request_pc + 32'd4;

   btb_victim_select #(
      .WIDTH    (WIDTH),
      .LINE_NUM (LINE_NUM)
   ) u_victim_select (
      .valid     (valid),
      .rr_ptr    (rr_ptr),
      .victim    (victim),
      .all_valid (all_valid)
   );

   assign wr_idx = upd_hit ? upd_idx : victim;

`ifdef BTB_FLUSH_EN
   assign write_go = update_en && !flush;
`else
   assign write_go = update_en;
`endif

   // NOTE: tag/target are qualified by valid, so they are plain RAM with no reset term.
   always_ff @(posedge clk) begin
      if (write_go && !reset) begin
         tag_mem[wr_idx]    <= update_pc[TAG_HI:TAG_LO];
         target_mem[wr_idx] <= update_target;
      end
   end

   // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid                  <= '0;
         rr_ptr                 <= '0;
         replace_en             <= 1'b0;
         fresh_en               <= 1'b0;
         replace_line_index     <= '0;
         fresh_line_index       <= '0;
         static_branch_predict  <= 1'b0;
         dynamic_branch_predict <= 1'b0;
      end
`ifdef BTB_FLUSH_EN
      else if (flush) begin
         valid      <= '0;
         rr_ptr     <= '0;
         replace_en <= 1'b0;
         fresh_en   <= 1'b0;
      end
`endif
      else begin
         replace_en <= 1'b0;
         fresh_en   <= 1'b0;
         if (update_en) begin
            if (upd_hit) begin
               fresh_en               <= 1'b1;
               fresh_line_index       <= upd_idx;
               dynamic_branch_predict <= dir_of(update_taken);
            end else begin
               valid[victim]         <= 1'b1;
               replace_en            <= 1'b1;
               replace_line_index    <= victim;
               static_branch_predict <= dir_of(update_taken);
               if (all_valid) rr_ptr <= rr_ptr + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Scoreboard bench for branch_target_buffer: directed updates push expected commands, a monitor checks them.
module tb_branch_target_buffer;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      request_pc;
   logic             request_state;
   logic [WIDTH-1:0] request_line_index;
   logic             request_miss;
   logic [31:0]      predict_pc;
   logic             update_en;
   logic [31:0]      update_pc;
   logic [31:0]      update_target;
   logic             update_taken;
   logic             replace_en;
   logic [WIDTH-1:0] replace_line_index;
   logic             static_branch_predict;
   logic             fresh_en;
   logic [WIDTH-1:0] fresh_line_index;
   logic             dynamic_branch_predict;
`ifdef BTB_FLUSH_EN
   logic             flush;
`endif

   always #5 clk = ~clk;

   branch_target_buffer #(.WIDTH(WIDTH), .LINE_NUM(16)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .request_pc             (request_pc),
      .request_state          (request_state),
      .request_line_index     (request_line_index),
      .request_miss           (request_miss),
      .predict_pc             (predict_pc),
      .update_en              (update_en),
      .update_pc              (update_pc),
      .update_target          (update_target),
      .update_taken           (update_taken),
      .replace_en             (replace_en),
      .replace_line_index     (replace_line_index),
      .static_branch_predict  (static_branch_predict),
      .fresh_en               (fresh_en),
      .fresh_line_index       (fresh_line_index),
      .dynamic_branch_predict (dynamic_branch_predict)
`ifdef BTB_FLUSH_EN
      ,
      .flush                  (flush)
`endif
   );

   typedef struct {
      logic             rep;
      logic [WIDTH-1:0] idx;
      logic             dir;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every replace/fresh pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && (replace_en || fresh_en)) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got replace_en=%b fresh_en=%b expected no pulse",
                     replace_en, fresh_en);
         end else begin
            e = sb.pop_front();
            check("pulse_kind", 32'({replace_en, fresh_en}), 32'({e.rep, ~e.rep}));
            check("pulse_idx", 32'(replace_en ? replace_line_index : fresh_line_index), 32'(e.idx));
            check("pulse_dir", 32'(replace_en ? static_branch_predict : dynamic_branch_predict),
                  32'(e.dir));
            check("pulse_cycle", 32'(cyc), 32'(e.cyc + 1));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                      input logic rep, input logic [WIDTH-1:0] idx);
      update_en     = 1'b1;
      update_pc     = pc;
      update_target = tgt;
      update_taken  = tk;
      sb.push_back('{rep: rep, idx: idx, dir: ~tk, cyc: cyc});
   endtask

   task automatic look(input logic [31:0] pc, input logic st, input logic miss,
                       input logic [WIDTH-1:0] idx, input logic [31:0] pred, input string nm);
      request_pc    = pc;
      request_state = st;
      @(negedge clk);
      check({nm, "_miss"}, 32'(request_miss), 32'(miss));
      check({nm, "_idx"}, 32'(request_line_index), 32'(idx));
      check({nm, "_pred"}, predict_pc, pred);
   endtask

   initial begin
      reset         = 1'b1;
      update_en     = 1'b0;
      update_pc     = '0;
      update_target = '0;
      update_taken  = 1'b0;
      request_pc    = '0;
      request_state = 1'b0;
`ifdef BTB_FLUSH_EN
      flush         = 1'b0;
`endif
      tick();
      tick();

      // Update presented while in reset is discarded.
      update_en     = 1'b1;
      update_pc     = 32'h0040_0010;
      update_target = 32'h0000_dead;
      update_taken  = 1'b1;
      @(negedge clk);
      check("rst_replace_en", 32'(replace_en), 32'd0);
      check("rst_fresh_en", 32'(fresh_en), 32'd0);
      check("rst_replace_idx", 32'(replace_line_index), 32'd0);
      check("rst_fresh_idx", 32'(fresh_line_index), 32'd0);
      check("rst_static", 32'(static_branch_predict), 32'd0);
      check("rst_dynamic", 32'(dynamic_branch_predict), 32'd0);
      tick();
      reset     = 1'b0;
      update_en = 1'b0;

      look(32'h0040_0000, 1'b0, 1'b1, 0, 32'h0040_0004, "cold_miss");
      look(32'h0040_0010, 1'b1, 1'b1, 0, 32'h0040_0014, "reset_discard");
      tick();

      // First allocation; same-cycle lookup must still miss.
      upd(32'h0040_0010, 32'h0040_0100, 1'b1, 1'b1, 0);
      look(32'h0040_0010, 1'b1, 1'b1, 0, 32'h0040_0014, "same_cycle_old");
      tick();
      update_en = 1'b0;
      look(32'h0040_0010, 1'b1, 1'b0, 0, 32'h0040_0100, "hit_taken");
      look(32'h0040_0010, 1'b0, 1'b0, 0, 32'h0040_0014, "hit_state0");
      tick();

      // Hits train the line and overwrite the target.
      upd(32'h0040_0010, 32'h0040_0100, 1'b0, 1'b0, 0);
      tick();
      upd(32'h0040_0010, 32'h0040_0200, 1'b1, 1'b0, 0);
      tick();
      update_en = 1'b0;
      look(32'h0040_0010, 1'b1, 1'b0, 0, 32'h0040_0200, "target_overwrite");
      tick();

      upd(32'h0040_0020, 32'h0040_0300, 1'b1, 1'b1, 1);
      look(32'h0040_0020, 1'b1, 1'b1, 0, 32'h0040_0024, "alloc_same_cycle");
      tick();
      update_en = 1'b0;
      look(32'h0040_0020, 1'b1, 1'b0, 1, 32'h0040_0300, "alloc_next_cycle");
      tick();

      // Back-to-back updates of one new PC: allocate then train, no duplicate line.
      upd(32'h0040_0030, 32'h0040_0400, 1'b0, 1'b1, 2);
      tick();
      upd(32'h0040_0030, 32'h0040_0400, 1'b1, 1'b0, 2);
      tick();

      for (int k = 3; k < 16; k++) begin
         upd(32'h0040_1000 + 32'(k) * 32'd16, 32'h0040_1100 + 32'(k) * 32'd16,
             k[0], 1'b1, WIDTH'(k));
         tick();
      end
      update_en = 1'b0;
      look(32'h0040_0030, 1'b0, 1'b0, 2, 32'h0040_0034, "dup_free");
      tick();

      // Full buffer: round-robin victims 0, 1, 2.
      upd(32'h0040_2000, 32'h0040_2100, 1'b1, 1'b1, 0);
      tick();
      upd(32'h0040_2010, 32'h0040_2110, 1'b0, 1'b1, 1);
      tick();
      upd(32'h0040_2020, 32'h0040_2120, 1'b1, 1'b1, 2);
      tick();
      update_en = 1'b0;
      look(32'h0040_0010, 1'b1, 1'b1, 0, 32'h0040_0014, "evicted0");
      look(32'h0040_2010, 1'b1, 1'b0, 1, 32'h0040_2110, "new_line1");
      look(32'h0040_10f0, 1'b1, 1'b0, 15, 32'h0040_11f0, "line15");
      look(32'hffff_fffc, 1'b0, 1'b1, 0, 32'h0000_0000, "pc_wrap");

`ifdef BTB_FLUSH_EN
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      look(32'h0040_2000, 1'b1, 1'b1, 0, 32'h0040_2004, "flush_miss");
      look(32'h0040_1030, 1'b1, 1'b1, 0, 32'h0040_1034, "flush_miss3");
      tick();
      flush         = 1'b1;
      update_en     = 1'b1;
      update_pc     = 32'h0040_3000;
      update_target = 32'h0040_3100;
      update_taken  = 1'b1;
      tick();
      flush     = 1'b0;
      update_en = 1'b0;
      look(32'h0040_3000, 1'b1, 1'b1, 0, 32'h0040_3004, "flush_wins");
      tick();
      upd(32'h0040_3000, 32'h0040_3100, 1'b1, 1'b1, 0);
      tick();
      update_en = 1'b0;
`endif

      // Reset mid-run clears contents and drops a same-cycle update.
      tick();
      reset         = 1'b1;
      update_en     = 1'b1;
      update_pc     = 32'h0040_5000;
      update_target = 32'h0040_5100;
      update_taken  = 1'b0;
      tick();
      reset     = 1'b0;
      update_en = 1'b0;
      look(32'h0040_2010, 1'b1, 1'b1, 0, 32'h0040_2014, "post_reset_miss");
      check("post_reset_replace_en", 32'(replace_en), 32'd0);
      tick();
      upd(32'h0040_5000, 32'h0040_5100, 1'b0, 1'b1, 0);
      tick();
      update_en = 1'b0;
      tick();
      tick();

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
